// File: rtl/minisys_pkg.sv
// Shared constants and types for the minisys IF stage.
package minisys_pkg;

  localparam logic [31:0] NOP_INSTR    = '0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_JR,
    NPC_J,
    NPC_FALLBACK,
    NPC_TAKEN,
    NPC_SEQ
  } npc_sel_e;

  // Predicted-taken target: PC+4 plus the sign-extended word offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus_4,
                                                input logic [15:0] imm);
    return pc_plus_4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_predict_if.sv
// Fetch-side bus: instruction memory, ID redirect feedback and IF/ID latch.
interface ifetch_predict_if;
  logic [31:0] IF_instruction;
  logic        IFBranch;
  logic        id_stall;
  logic        nBranch;
  logic        J;
  logic        JR;
  logic [31:0] rs;
  logic [31:0] PC;
  logic [5:0]  IF_op;
  logic [31:0] ID_instruction;
  logic [31:0] ID_PC_plus_4;

  modport master (
    input  IF_instruction, IFBranch, id_stall, nBranch, J, JR, rs,
    output PC, IF_op, ID_instruction, ID_PC_plus_4
  );

  modport slave (
    output IF_instruction, IFBranch, id_stall, nBranch, J, JR, rs,
    input  PC, IF_op, ID_instruction, ID_PC_plus_4
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ifetch_predict.sv
// IF stage: PC register, static predict-taken next-PC mux, IF/ID latch
// and branch/mispredict statistics.
module ifetch_predict
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  ifetch_predict_if.master     bus,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispredict_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ip4_q, ip4_d;
  logic [31:0] fb_q, fb_d;
  logic        isb_q, isb_d;
  logic [31:0] pc_plus_4;
  npc_sel_e    sel;
  logic        br_inc;
  logic        mp_inc;

  assign pc_plus_4 = pc_q + 32'd4;

  // Pick the next-PC source by fixed priority.
  always_comb begin
    sel = NPC_SEQ;
    if (bus.id_stall)     sel = NPC_HOLD;
    else if (bus.JR)      sel = NPC_JR;
    else if (bus.J)       sel = NPC_J;
    else if (bus.nBranch) sel = NPC_FALLBACK;
    else if (bus.IFBranch) sel = NPC_TAKEN;
  end

  // Next values for PC, IF/ID latch and prediction state.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    ip4_d = ip4_q;
    fb_d  = fb_q;
    isb_d = isb_q;
    unique case (sel)
      NPC_HOLD: ;
      NPC_JR: begin
        pc_d  = bus.rs;
        ir_d  = NOP_INSTR;
        ip4_d = '0;
        isb_d = 1'b0;
      end
      NPC_J: begin
        pc_d  = {ip4_q[31:28], ir_q[25:0], 2'b00};
        ir_d  = NOP_INSTR;
        ip4_d = '0;
        isb_d = 1'b0;
      end
      NPC_FALLBACK: begin
        pc_d  = fb_q;
        ir_d  = NOP_INSTR;
        ip4_d = '0;
        isb_d = 1'b0;
      end
      NPC_TAKEN: begin
        pc_d  = branch_target(pc_plus_4, bus.IF_instruction[15:0]);
        fb_d  = pc_plus_4;
        ir_d  = bus.IF_instruction;
        ip4_d = pc_plus_4;
        isb_d = 1'b1;
      end
      default: begin
        pc_d  = pc_plus_4;
        ir_d  = bus.IF_instruction;
        ip4_d = pc_plus_4;
        isb_d = 1'b0;
      end
    endcase
  end

  // PC, IF/ID and fallback registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= NOP_INSTR;
      ip4_q <= '0;
      fb_q  <= '0;
      isb_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      ip4_q <= ip4_d;
      fb_q  <= fb_d;
      isb_q <= isb_d;
    end
  end

  // A mispredict is only counted when it actually redirects fetch; a
  // concurrent J/JR means the ID instruction is not a branch.
  assign br_inc = isb_q && !bus.id_stall;
  assign mp_inc = (sel == NPC_FALLBACK);

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (br_inc),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (mp_inc),
    .count (mispredict_count)
  );

  assign bus.PC             = pc_q;
  assign bus.IF_op          = bus.IF_instruction[31:26];
  assign bus.ID_instruction = ir_q;
  assign bus.ID_PC_plus_4   = ip4_q;

endmodule

// File: tb/tb_ifetch_predict.sv
// Self-checking bench for ifetch_predict: reference model plus directed
// scenarios with literal expectations.
module tb_ifetch_predict;
  import minisys_pkg::*;

  localparam int unsigned TB_CNT_W = 3;
  localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] NONBR    = 32'h2408_0001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [TB_CNT_W-1:0] branch_count;
  logic [TB_CNT_W-1:0] mispredict_count;

  ifetch_predict_if bus ();

  ifetch_predict #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus.master),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state, expressed as architectural quantities.
  logic [31:0] m_pc = 32'h0, m_ir = 32'h0, m_ip4 = 32'h0, m_fb = 32'h0;
  bit          m_br_in_id = 0;
  int unsigned m_bc = 0, m_mc = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0; m_ir = 32'h0; m_ip4 = 32'h0; m_fb = 32'h0;
      m_br_in_id = 0; m_bc = 0; m_mc = 0;
    end else if (!bus.id_stall) begin
      logic [31:0] seq;
      logic [31:0] off;
      seq = m_pc + 32'd4;
      if (m_br_in_id && m_bc < CNT_MAX) m_bc++;
      if (bus.JR || bus.J || bus.nBranch) begin
        if (bus.JR)     m_pc = bus.rs;
        else if (bus.J) m_pc = {m_ip4[31:28], m_ir[25:0], 2'b00};
        else begin
          m_pc = m_fb;
          if (m_mc < CNT_MAX) m_mc++;
        end
        m_ir = 32'h0; m_ip4 = 32'h0; m_br_in_id = 0;
      end else begin
        m_ir = bus.IF_instruction; m_ip4 = seq;
        m_br_in_id = bus.IFBranch;
        if (bus.IFBranch) begin
          off  = 32'($signed(bus.IF_instruction[15:0])) * 4;
          m_fb = seq;
          m_pc = seq + off;
        end else begin
          m_pc = seq;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("pc", bus.PC, m_pc);
      check("if_op", {26'h0, bus.IF_op}, {26'h0, bus.IF_instruction[31:26]});
      check("id_instr", bus.ID_instruction, m_ir);
      check("id_pc4", bus.ID_PC_plus_4, m_ip4);
      check("branch_count", 32'(branch_count), m_bc);
      check("mispredict_count", 32'(mispredict_count), m_mc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.IF_instruction = NONBR;
    bus.IFBranch = 0; bus.id_stall = 0; bus.nBranch = 0;
    bus.J = 0; bus.JR = 0; bus.rs = 32'h0;
    #2 reset = 0;
    #1 chk_en = 1;
    check("rst_pc", bus.PC, 32'h0);
    check("rst_id_instr", bus.ID_instruction, 32'h0);
    check("rst_cnt", 32'(mispredict_count), 32'h0);
    tick(); tick();
    reset = 1;

    // Sequential fetch.
    tick(); check("seq_pc4", bus.PC, 32'h4);
    tick(); check("seq_pc8", bus.PC, 32'h8);
    check("seq_id_pc4", bus.ID_PC_plus_4, 32'h8);
    tick(); tick(); check("seq_pc10", bus.PC, 32'h10);

    // Predicted-taken branch then mispredict.
    bus.IFBranch = 1; bus.IF_instruction = {OP_BEQ, 5'd1, 5'd2, 16'h0003};
    tick(); check("br_target", bus.PC, 32'h20);
    check("br_id_pc4", bus.ID_PC_plus_4, 32'h14);
    bus.IFBranch = 0; bus.IF_instruction = NONBR; bus.nBranch = 1;
    tick(); check("nbr_pc", bus.PC, 32'h14);
    check("nbr_id_nop", bus.ID_instruction, 32'h0);
    check("nbr_mc", 32'(mispredict_count), 32'd1);
    check("nbr_bc", 32'(branch_count), 32'd1);

    // J with IF branch squashed.
    bus.nBranch = 0; bus.JR = 1; bus.rs = 32'h0040_0004;
    tick(); check("jr_pc", bus.PC, 32'h0040_0004);
    bus.JR = 0; bus.IF_instruction = {OP_J, 26'h000_0100};
    tick(); check("j_id_pc4", bus.ID_PC_plus_4, 32'h0040_0008);
    bus.J = 1; bus.IFBranch = 1; bus.IF_instruction = {OP_BNE, 5'd1, 5'd0, 16'h0004};
    tick(); check("j_pc", bus.PC, 32'h0000_0400);
    check("j_id_nop", bus.ID_instruction, 32'h0);

    // JR beats nBranch.
    bus.J = 0; bus.IFBranch = 0; bus.IF_instruction = NONBR;
    bus.JR = 1; bus.nBranch = 1; bus.rs = 32'h0000_1000;
    tick(); check("jr_win_pc", bus.PC, 32'h1000);
    check("jr_win_mc", 32'(mispredict_count), 32'd1);

    // Branch, then a 3-cycle stall with a spurious nBranch.
    bus.JR = 0; bus.nBranch = 0; bus.IFBranch = 1;
    bus.IF_instruction = {OP_BNE, 5'd3, 5'd0, 16'h0010};
    tick(); check("br2_pc", bus.PC, 32'h1044);
    bus.IFBranch = 0; bus.IF_instruction = NONBR; bus.id_stall = 1; bus.nBranch = 1;
    repeat (3) tick();
    check("stall_pc", bus.PC, 32'h1044);
    check("stall_bc", 32'(branch_count), 32'd1);
    check("stall_mc", 32'(mispredict_count), 32'd1);
    bus.id_stall = 0; bus.nBranch = 0;
    tick(); check("unstall_pc", bus.PC, 32'h1048);
    check("unstall_bc", 32'(branch_count), 32'd2);

    // Backward branch, then saturate the mispredict counter.
    bus.IFBranch = 1; bus.IF_instruction = {OP_BEQ, 5'd0, 5'd0, 16'hFFF0};
    tick(); check("back_br_pc", bus.PC, 32'h100C);
    bus.IFBranch = 0; bus.IF_instruction = NONBR; bus.nBranch = 1;
    repeat (8) tick();
    check("mc_sat", 32'(mispredict_count), 32'd7);
    check("sat_pc", bus.PC, 32'h104C);

    // PC wrap.
    bus.nBranch = 0; bus.JR = 1; bus.rs = 32'hFFFF_FFFC;
    tick(); bus.JR = 0;
    tick(); check("wrap_pc", bus.PC, 32'h0);

    // Asynchronous reset between edges at PC=0x80.
    bus.JR = 1; bus.rs = 32'h0000_0080;
    tick(); bus.JR = 0;
    check("pre_rst_pc", bus.PC, 32'h80);
    #2 reset = 0;
    #1;
    check("arst_pc", bus.PC, 32'h0);
    check("arst_bc", 32'(branch_count), 32'h0);
    check("arst_mc", 32'(mispredict_count), 32'h0);
    #1 reset = 1;
    tick(); check("post_rst_pc", bus.PC, 32'h4);

    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
